a1_scaler_sched: RTL
====================

# a1_scaler_sched

Scheduler for the A1 scaler's divided-frequency outputs. It captures rising edges on selected scaler stage taps (FS-series levels), holds one pending increment request per tap, and hands them one at a time to the counter-cell sequencer in the slots the timing section offers. It sits between the scaler chain and the involuntary-counter priority logic. It turns free-running scaler transitions into an ordered, acknowledged request stream and flags any tap event lost to congestion.

## Interface
Parameters:
- NREQ, 5, number of scaler taps / requesters (1..8)
- IDW, 3, width of REQ_ID; must satisfy 2**IDW >= NREQ

Ports (one clock; reset is synchronous and active-high):
- SIM_CLK  in  1  system clock; all state updates on rising edge
- SIM_RST  in  1  synchronous active-high reset
- FS_TAP  in  NREQ  scaler stage levels, already synchronous to SIM_CLK; bit i = requester i
- ENABLE  in  1  permits new grants; edge capture continues when low
- SLOT  in  1  one-cycle strobe: counter sequencer can accept a request
- GRANT_ACK  in  1  sequencer accepted the current request
- REQ_VALID  out  1  request presented
- REQ_ID  out  IDW  index of presented requester
- PENDING  out  NREQ  pending-request bitmap
- OVERFLOW  out  NREQ  sticky lost-event flags

## Operation
- Edge capture, per tap:
  - PREV[i] <= FS_TAP[i].
  - A rising edge is FS_TAP[i] & ~PREV[i]. It sets PENDING[i].
- Overflow:
  - Set OVERFLOW[i] when an edge arrives while PENDING[i] is already 1 and PENDING[i] is not being cleared in the same cycle.
  - OVERFLOW[i] clears only on SIM_RST.
- Edge coinciding with the clear of the same bit: PENDING[i] stays 1 (the new event is retained) and OVERFLOW[i] is not set.
- State machine, two states:
  - IDLE: REQ_VALID=0. If SLOT & ENABLE & |PENDING, latch the selected index into REQ_ID and go to BUSY. Otherwise stay in IDLE.
  - BUSY: REQ_VALID=1 and REQ_ID held stable. On GRANT_ACK, clear PENDING[REQ_ID] and go to IDLE. SLOT is ignored.
- Selection: fixed priority, lowest pending index wins (see Configuration).
- ENABLE deasserted in BUSY does not withdraw the request; it still completes on GRANT_ACK.
- GRANT_ACK in IDLE is ignored.
- Reset values: REQ_VALID=0, REQ_ID=0, PENDING=0, OVERFLOW=0, PREV=0, state=IDLE.
- An FS_TAP level of 1 at reset release counts as an edge on the first cycle.

## Timing
- Edge on FS_TAP visible in cycle k → PENDING[i]=1 in cycle k+1.
- SLOT sampled in cycle n (IDLE, eligible) → REQ_VALID=1 with REQ_ID in cycle n+1.
- GRANT_ACK sampled in cycle m → REQ_VALID=0 and PENDING bit cleared in cycle m+1.
- Minimum spacing between grants is 2 cycles, since ACK returns to IDLE and the next SLOT must be sampled there.
- SIM_RST asserted in cycle r → all outputs at reset values in cycle r+1, including mid-BUSY. A GRANT_ACK in cycle r has no effect.

## Configuration
- SCALER_SCHED_RR_EN defined: round-robin selection.
  - A pointer LAST (reset 0) holds the index of the last granted requester.
  - The winner is the first pending index strictly after LAST, wrapping modulo NREQ.
  - LAST updates on entry to BUSY.
- Not defined: fixed priority, lowest pending index wins; no pointer is built.

## Structure
- Shared package a1_scaler_pkg holds:
  - NREQ and IDW defaults
  - the state encoding constants S_IDLE=0 and S_BUSY=1
- One sub-module, a1_tap_latch, instantiated NREQ times. It owns PREV, edge detect, the PENDING bit and the OVERFLOW bit. Its inputs are tap, clr, clk and rst.
- Arbitration and the FSM live in the top level.

## Test plan
- Reset release with FS_TAP=0, then tap 2 rises at cycle 5 → PENDING=00100 at cycle 6. SLOT at cycle 8 → REQ_VALID=1 and REQ_ID=2 at cycle 9. ACK at cycle 11 → PENDING=0 and REQ_VALID=0 at cycle 12.
- Taps 1 and 3 pending, SLOT pulsed twice with an ACK after each:
  - Fixed priority: grant order 1 then 3.
  - RR_EN with LAST=1: grant order 3 then 1.
- Tap 0 pending and not granted, second rising edge on tap 0 → OVERFLOW[0]=1 and PENDING[0] stays 1. OVERFLOW[0] remains 1 after the grant and ACK.
- Tap 4 edge in the same cycle as ACK with REQ_ID=4 → PENDING[4]=1 next cycle, OVERFLOW[4]=0. The next SLOT grants ID 4 again.
- ENABLE=0 with SLOT pulses and PENDING=00001 → REQ_VALID stays 0. Raising ENABLE before the next SLOT gives a grant one cycle after that SLOT.
- SIM_RST in BUSY with REQ_ID=3 → next cycle REQ_VALID=0, PENDING=0, OVERFLOW=0. A late ACK has no effect.

Source files
------------

// File: rtl/a1_scaler_pkg.sv
// Shared definitions for the A1 scaler request scheduler.
// Holds default sizing and the scheduler state encoding.
package a1_scaler_pkg;

   localparam int NREQ_DEF = 5;
   localparam int IDW_DEF  = 3;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/a1_tap_latch.sv
// Per-tap edge capture with one pending slot and a sticky lost-event flag.
// Ports: clk, rst (sync, active-high), tap level, clr (grant done),
//        pending (request held), overflow (event dropped while pending).
module a1_tap_latch
   import a1_scaler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tap,
   input  logic clr,
   output logic pending,
   output logic overflow
);

   logic prev;
   logic rise;

   assign rise = tap & ~prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= 1'b0;
         pending  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         prev <= tap;
         // An edge landing on the clearing cycle refills the slot
         // instead of counting as a lost event.
         pending <= rise | (pending & ~clr);
         if (rise & pending & ~clr)
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/a1_scaler_sched.sv
// A1 scaler scheduler: captures tap edges, arbitrates, hands out one
// acknowledged request at a time and flags events lost to congestion.
// Ports: SIM_CLK, SIM_RST (sync, active-high), FS_TAP, ENABLE, SLOT,
//        GRANT_ACK in; REQ_VALID, REQ_ID, PENDING, OVERFLOW out.
// Build option: define SCALER_SCHED_RR_EN for round-robin selection;
// default is fixed priority, lowest pending index wins.
module a1_scaler_sched
   import a1_scaler_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF
) (
   input  logic            SIM_CLK,
   input  logic            SIM_RST,
   input  logic [NREQ-1:0] FS_TAP,
   input  logic            ENABLE,
   input  logic            SLOT,
   input  logic            GRANT_ACK,
   output logic            REQ_VALID,
   output logic [IDW-1:0]  REQ_ID,
   output logic [NREQ-1:0] PENDING,
   output logic [NREQ-1:0] OVERFLOW
);

   state_t          state;
   logic [NREQ-1:0] clr;
   logic [IDW-1:0]  sel_id;
   logic            sel_hit;

`ifdef SCALER_SCHED_RR_EN
   logic [IDW-1:0]  last;
   int              rr_idx;
`endif

   for (genvar i = 0; i < NREQ; i++) begin : g_tap
      a1_tap_latch u_tap (
         .clk      (SIM_CLK),
         .rst      (SIM_RST),
         .tap      (FS_TAP[i]),
         .clr      (clr[i]),
         .pending  (PENDING[i]),
         .overflow (OVERFLOW[i])
      );
   end

   // Only the bit being served is released, and only on its ack.
   always_comb begin
      clr = '0;
      for (int i = 0; i < NREQ; i++)
         clr[i] = (state == S_BUSY) & GRANT_ACK
                  & (REQ_ID == IDW'(i));
   end

`ifdef SCALER_SCHED_RR_EN
   // Scan starts just past the last winner and wraps.
   always_comb begin
      sel_id  = '0;
      sel_hit = 1'b0;
      rr_idx  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         rr_idx = (int'(last) + k) % NREQ;
         if (!sel_hit && PENDING[rr_idx]) begin
            sel_hit = 1'b1;
            sel_id  = IDW'(rr_idx);
         end
      end
   end
`else
   // Descending scan so the lowest set index is written last.
   always_comb begin
      sel_id  = '0;
      sel_hit = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (PENDING[i]) begin
            sel_hit = 1'b1;
            sel_id  = IDW'(i);
         end
      end
   end
`endif

   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state     <= S_IDLE;
         REQ_VALID <= 1'b0;
         REQ_ID    <= '0;
`ifdef SCALER_SCHED_RR_EN
         last      <= '0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (SLOT && ENABLE && sel_hit) begin
                  state     <= S_BUSY;
                  REQ_VALID <= 1'b1;
                  REQ_ID    <= sel_id;
`ifdef SCALER_SCHED_RR_EN
                  last      <= sel_id;
`endif
               end
            end
            S_BUSY: begin
               // ENABLE and SLOT do not matter here; only the ack ends it.
               if (GRANT_ACK) begin
                  state     <= S_IDLE;
                  REQ_VALID <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
